// File: rtl/fwu_pkg.sv
// fwu_pkg: shared op/status encodings and SPI flash opcodes for the firmware-update flash sequencer
package fwu_pkg;
    typedef enum logic [1:0] {OP_READ, OP_PROGRAM, OP_ERASE_4K, OP_RSVD} op_code_e;
    typedef enum logic [1:0] {ST_OK, ST_BAD_ARG, ST_TIMEOUT, ST_WEL_FAIL} op_status_e;
    localparam logic [7:0] FL_READ = 8'h03;
    localparam logic [7:0] FL_PP   = 8'h02;
    localparam logic [7:0] FL_SE   = 8'h20;
    localparam logic [7:0] FL_WREN = 8'h06;
    localparam logic [7:0] FL_RDSR = 8'h05;
endpackage

// File: rtl/fwu_flash_seq.sv
// fwu_flash_seq: sequences READ/PROGRAM/ERASE_4K ops into SPI flash commands with WREN and RDSR polling.
// Define FWU_FLASH_SEQ_WEL_CHECK_EN to verify WEL with one RDSR after every WREN.
module fwu_flash_seq
    import fwu_pkg::*;
#(
    parameter int POLL_MAX = 4096,
    parameter int POLL_GAP = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [23:0] op_addr,
    input  logic [15:0] op_len,
    input  logic [7:0]  in_wr_data,
    input  logic        in_wr_valid,
    output logic        in_wr_ready,
    output logic [7:0]  out_rd_data,
    output logic        out_rd_valid,
    input  logic        out_rd_ready,
    output logic        op_done,
    output logic [1:0]  op_status,
    output logic        busy,
    output logic        flash_cmd_valid,
    input  logic        flash_cmd_ready,
    output logic [7:0]  flash_opcode,
    output logic [23:0] flash_addr,
    output logic [15:0] flash_len,
    output logic        flash_has_addr,
    output logic        flash_is_read,
    output logic        flash_is_write,
    output logic [7:0]  flash_wr_data,
    output logic        flash_wr_valid,
    input  logic        flash_wr_ready,
    input  logic [7:0]  flash_rd_data,
    input  logic        flash_rd_valid,
    output logic        flash_rd_ready,
    input  logic        flash_done
);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = $clog2(POLL_GAP + 1);
    typedef enum logic [3:0] {IDLE, WREN, WREN_WAIT, CMD, CMD_WAIT, POLL, POLL_WAIT, GAP, DONE} state_e;
    state_e     state, state_n;
    op_code_e   code;
    op_status_e status, status_n;
    logic [23:0]   addr;
    logic [15:0]   len;
    logic [7:0]    sr, sr_now, cmd_op;
    logic [PW-1:0] poll_cnt, poll_inc;
    logic [GW-1:0] gap_cnt;
    logic          bad, wel_mode, xfer_wr, xfer_rd;
    assign bad = op_code == OP_RSVD || (!op_code[1] && op_len == 16'd0) ||
                 (op_code == OP_PROGRAM && ({9'd0, op_addr[7:0]} + {1'b0, op_len}) > 17'd256);
    // status byte may arrive in the same cycle as flash_done
    assign sr_now   = flash_rd_valid ? flash_rd_data : sr;
    assign poll_inc = (poll_cnt == PW'(POLL_MAX)) ? poll_cnt : poll_cnt + 1'b1;
    always_comb begin
        state_n  = state;
        status_n = status;
        case (state)
            IDLE: if (op_valid) begin
                state_n  = bad ? DONE : (op_code == OP_READ) ? CMD : WREN;
                status_n = bad ? ST_BAD_ARG : ST_OK;
            end
            WREN: if (flash_cmd_ready) state_n = WREN_WAIT;
            WREN_WAIT: if (flash_done) state_n =
`ifdef FWU_FLASH_SEQ_WEL_CHECK_EN
                POLL;
`else
                CMD;
`endif
            CMD: if (flash_cmd_ready) state_n = CMD_WAIT;
            CMD_WAIT: if (flash_done) state_n = (code == OP_READ) ? DONE : POLL;
            POLL: if (flash_cmd_ready) state_n = POLL_WAIT;
            POLL_WAIT: if (flash_done) begin
                if (wel_mode) begin
                    state_n  = sr_now[1] ? CMD : DONE;
                    status_n = sr_now[1] ? status : ST_WEL_FAIL;
                end else if (!sr_now[0]) begin
                    state_n = DONE;
                end else begin
                    state_n  = (poll_inc == PW'(POLL_MAX)) ? DONE : GAP;
                    status_n = (poll_inc == PW'(POLL_MAX)) ? ST_TIMEOUT : status;
                end
            end
            GAP: if (gap_cnt == GW'(POLL_GAP - 1)) state_n = POLL;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            status   <= ST_OK;
            code     <= OP_READ;
            addr     <= '0;
            len      <= '0;
            sr       <= '0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state   <= state_n;
            status  <= status_n;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (state == IDLE && op_valid) begin
                code     <= op_code_e'(op_code);
                addr     <= op_addr;
                len      <= op_len;
                poll_cnt <= '0;
            end
            if (state == POLL_WAIT && flash_rd_valid) sr <= flash_rd_data;
            if (state == POLL_WAIT && flash_done && !wel_mode) poll_cnt <= poll_inc;
        end
    end
`ifdef FWU_FLASH_SEQ_WEL_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) wel_mode <= 1'b0;
        else if (state == WREN_WAIT && flash_done) wel_mode <= 1'b1;
        else if (state == POLL_WAIT && flash_done) wel_mode <= 1'b0;
    end
`else
    assign wel_mode = 1'b0;
`endif
    assign op_ready        = state == IDLE;
    assign busy            = state != IDLE;
    assign op_done         = state == DONE;
    assign op_status       = status;
    assign cmd_op          = (code == OP_READ) ? FL_READ : (code == OP_PROGRAM) ? FL_PP : FL_SE;
    assign flash_cmd_valid = state inside {WREN, CMD, POLL};
    assign flash_opcode    = (state == WREN) ? FL_WREN : (state == POLL) ? FL_RDSR : (state == CMD) ? cmd_op : 8'h00;
    assign flash_addr      = (state == CMD) ? addr : 24'h0;
    assign flash_len       = (state == POLL) ? 16'd1 : (state == CMD && code != OP_ERASE_4K) ? len : 16'd0;
    assign flash_has_addr  = state == CMD;
    assign flash_is_read   = state == POLL || (state == CMD && code == OP_READ);
    assign flash_is_write  = state == CMD && code == OP_PROGRAM;
    assign xfer_wr         = code == OP_PROGRAM && (state == CMD || state == CMD_WAIT);
    assign xfer_rd         = code == OP_READ && (state == CMD || state == CMD_WAIT);
    assign flash_wr_data   = in_wr_data;
    assign flash_wr_valid  = xfer_wr ? in_wr_valid : 1'b0;
    assign in_wr_ready     = xfer_wr ? flash_wr_ready : 1'b0;
    assign out_rd_data     = flash_rd_data;
    assign out_rd_valid    = xfer_rd ? flash_rd_valid : 1'b0;
    assign flash_rd_ready  = xfer_rd ? out_rd_ready : (state == POLL_WAIT);
endmodule

// File: tb/tb_fwu_flash_seq.sv
// tb_fwu_flash_seq: scoreboard bench with a behavioural SPI flash controller model.
// Honours FWU_FLASH_SEQ_WEL_CHECK_EN for the WEL-check build.
module tb_fwu_flash_seq;
    import fwu_pkg::*;
    localparam int PM = 8;
    localparam int PG = 64;
`ifdef FWU_FLASH_SEQ_WEL_CHECK_EN
    localparam int WEL_RDSR = 1;
`else
    localparam int WEL_RDSR = 0;
`endif
    logic clk, rst, op_valid, op_ready, in_wr_valid, in_wr_ready, out_rd_valid, out_rd_ready;
    logic [1:0] op_code, op_status;
    logic [23:0] op_addr, flash_addr;
    logic [15:0] op_len, flash_len;
    logic [7:0] in_wr_data, out_rd_data, flash_opcode, flash_wr_data, flash_rd_data;
    logic op_done, busy, flash_cmd_valid, flash_cmd_ready, flash_has_addr, flash_is_read, flash_is_write;
    logic flash_wr_valid, flash_wr_ready, flash_rd_valid, flash_rd_ready, flash_done;

    fwu_flash_seq #(.POLL_MAX(PM), .POLL_GAP(PG)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_addr(op_addr), .op_len(op_len), .in_wr_data(in_wr_data), .in_wr_valid(in_wr_valid),
        .in_wr_ready(in_wr_ready), .out_rd_data(out_rd_data), .out_rd_valid(out_rd_valid),
        .out_rd_ready(out_rd_ready), .op_done(op_done), .op_status(op_status), .busy(busy),
        .flash_cmd_valid(flash_cmd_valid), .flash_cmd_ready(flash_cmd_ready), .flash_opcode(flash_opcode),
        .flash_addr(flash_addr), .flash_len(flash_len), .flash_has_addr(flash_has_addr),
        .flash_is_read(flash_is_read), .flash_is_write(flash_is_write), .flash_wr_data(flash_wr_data),
        .flash_wr_valid(flash_wr_valid), .flash_wr_ready(flash_wr_ready), .flash_rd_data(flash_rd_data),
        .flash_rd_valid(flash_rd_valid), .flash_rd_ready(flash_rd_ready), .flash_done(flash_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flash controller model: phase 0 idle, 1 data, 2 done pulse
    logic [1:0]  m_phase;
    logic [15:0] m_cnt, m_len;
    logic        m_read, m_write, m_rdsr, m_tog;
    logic [7:0]  m_sr;
    int          m_rdsr_cnt;
    int          wip_polls;
    logic        wel_bit;
    assign flash_cmd_ready = m_phase == 2'd0 && m_tog;
    assign flash_rd_valid  = m_phase == 2'd1 && m_read && m_cnt != m_len;
    assign flash_rd_data   = m_rdsr ? m_sr : 8'hA0 + m_cnt[7:0];
    assign flash_wr_ready  = m_phase == 2'd1 && m_write && m_cnt != m_len;
    assign flash_done      = m_phase == 2'd2;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 2'd0; m_cnt <= '0; m_len <= '0; m_read <= 1'b0; m_write <= 1'b0;
            m_rdsr <= 1'b0; m_tog <= 1'b0; m_sr <= '0; m_rdsr_cnt <= 0;
        end else begin
            m_tog <= ~m_tog;
            if (op_valid && op_ready) m_rdsr_cnt <= 0;
            case (m_phase)
                2'd0: if (flash_cmd_valid && flash_cmd_ready) begin
                    m_phase <= 2'd1; m_cnt <= '0; m_len <= flash_len;
                    m_read <= flash_is_read; m_write <= flash_is_write;
                    m_rdsr <= flash_opcode == FL_RDSR;
                    if (flash_opcode == FL_RDSR) begin
                        m_sr <= {6'd0, wel_bit, m_rdsr_cnt < wip_polls};
                        m_rdsr_cnt <= m_rdsr_cnt + 1;
                    end
                end
                2'd1: if (m_cnt == m_len) m_phase <= 2'd2;
                      else if ((flash_rd_valid && flash_rd_ready) || (flash_wr_valid && flash_wr_ready)) m_cnt <= m_cnt + 1'b1;
                default: m_phase <= 2'd0;
            endcase
        end
    end

    logic [47:0] exp_cmd[$];
    logic [7:0]  exp_rd[$];
    logic [1:0]  exp_st[$];
    int cyc = 0, t_done = -1, n_done = 0, wr_cnt = 0, rd_cnt = 0;
    logic prev_valid = 1'b0;
    assign in_wr_data = 8'(wr_cnt);

    // scoreboard: sampled on the falling edge, between DUT updates
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (flash_cmd_valid && flash_cmd_ready)
                check("cmd", {flash_opcode, flash_addr, flash_len}, exp_cmd.size() != 0 ? exp_cmd.pop_front() : 48'h0);
            if (flash_cmd_valid && !prev_valid && flash_opcode == FL_RDSR && t_done >= 0)
                check("poll_gap", 64'(cyc - t_done), 64'(PG + 1));
            if (flash_done) t_done = m_rdsr ? cyc : -1;
            if (out_rd_valid && out_rd_ready) begin
                check("rd_data", out_rd_data, exp_rd.size() != 0 ? 64'(exp_rd.pop_front()) : 64'hDEAD);
                rd_cnt++;
            end
            if (in_wr_valid && in_wr_ready) wr_cnt++;
            if (op_done) begin
                check("status", op_status, exp_st.size() != 0 ? 64'(exp_st.pop_front()) : 64'hDEAD);
                n_done++;
            end
        end else t_done = -1;
        prev_valid = flash_cmd_valid;
    end

    task automatic push_wren();
        exp_cmd.push_back({FL_WREN, 24'h0, 16'h0});
`ifdef FWU_FLASH_SEQ_WEL_CHECK_EN
        exp_cmd.push_back({FL_RDSR, 24'h0, 16'h1});
`endif
    endtask

    task automatic push_rdsr(input int n);
        for (int i = 0; i < n; i++) exp_cmd.push_back({FL_RDSR, 24'h0, 16'h1});
    endtask

    task automatic push_rd(input int n);
        for (int i = 0; i < n; i++) exp_rd.push_back(8'hA0 + 8'(i));
    endtask

    task automatic issue(input logic [1:0] c, input logic [23:0] a, input logic [15:0] l);
        bit acc;
        op_code = c; op_addr = a; op_len = l; op_valid = 1'b1;
        acc = op_ready;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = op_ready;
        end
        @(negedge clk);
        op_valid = 1'b0;
        check("accept", acc, 1);
        check("busy_run", {busy, op_ready}, 2'b10);
    endtask

    task automatic do_op(input logic [1:0] c, input logic [23:0] a, input logic [15:0] l,
                         input logic [1:0] st, input int ew, input int er);
        int wb, rb, db;
        wb = wr_cnt; rb = rd_cnt; db = n_done;
        exp_st.push_back(st);
        issue(c, a, l);
        #1;
        for (int i = 0; i < 20000 && n_done == db; i++) begin
            @(negedge clk);
            #1;
        end
        check("op_done", 64'(n_done - db), 1);
        @(negedge clk);
        check("idle_after", {busy, op_ready, op_done}, 3'b010);
        check("cmds_left", 64'(exp_cmd.size()), 0);
        check("rd_left", 64'(exp_rd.size()), 0);
        check("wr_bytes", 64'(wr_cnt - wb), 64'(ew));
        check("rd_bytes", 64'(rd_cnt - rb), 64'(er));
        exp_cmd.delete(); exp_rd.delete(); exp_st.delete();
    endtask

    initial begin
        int wb;
        rst = 1'b1; op_valid = 1'b0; op_code = 2'd0; op_addr = '0; op_len = '0;
        in_wr_valid = 1'b1; out_rd_ready = 1'b1; wip_polls = 0; wel_bit = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctl", {busy, op_ready, op_done, op_status, flash_cmd_valid}, 6'b010000);
        check("rst_fields", {flash_opcode, flash_addr, flash_len, flash_has_addr, flash_is_read, flash_is_write}, 0);
        rst = 1'b0;
        @(negedge clk);

        exp_cmd.push_back({FL_READ, 24'h001000, 16'd4}); push_rd(4);
        do_op(OP_READ, 24'h001000, 16'd4, ST_OK, 0, 4);

        wip_polls = 3 + WEL_RDSR;
        push_wren(); exp_cmd.push_back({FL_PP, 24'h0000F0, 16'd16}); push_rdsr(4);
        do_op(OP_PROGRAM, 24'h0000F0, 16'd16, ST_OK, 16, 0);

        do_op(OP_PROGRAM, 24'h0000F8, 16'd16, ST_BAD_ARG, 0, 0);
        do_op(OP_READ, 24'h000000, 16'd0, ST_BAD_ARG, 0, 0);
        do_op(OP_RSVD, 24'h000000, 16'd4, ST_BAD_ARG, 0, 0);
        do_op(OP_PROGRAM, 24'h000200, 16'd257, ST_BAD_ARG, 0, 0);
        do_op(OP_PROGRAM, 24'h000000, 16'd0, ST_BAD_ARG, 0, 0);

        wip_polls = WEL_RDSR;
        push_wren(); exp_cmd.push_back({FL_PP, 24'h000300, 16'd256}); push_rdsr(1);
        do_op(OP_PROGRAM, 24'h000300, 16'd256, ST_OK, 256, 0);
        push_wren(); exp_cmd.push_back({FL_PP, 24'h0001FF, 16'd1}); push_rdsr(1);
        do_op(OP_PROGRAM, 24'h0001FF, 16'd1, ST_OK, 1, 0);

        wip_polls = 100000;
        push_wren(); exp_cmd.push_back({FL_SE, 24'h003000, 16'd0}); push_rdsr(PM);
        do_op(OP_ERASE_4K, 24'h003000, 16'd0, ST_TIMEOUT, 0, 0);

        wip_polls = 0;
        push_wren(); exp_cmd.push_back({FL_PP, 24'h000000, 16'd16});
        wb = wr_cnt;
        issue(OP_PROGRAM, 24'h000000, 16'd16);
        #1;
        for (int i = 0; i < 500 && wr_cnt - wb < 4; i++) begin
            @(negedge clk);
            #1;
        end
        check("rst_xfer_started", 64'(wr_cnt - wb >= 4), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_xfer", {busy, op_ready, op_done, flash_cmd_valid, in_wr_ready}, 5'b01000);
        rst = 1'b0;
        exp_cmd.delete();
        @(negedge clk);
        exp_cmd.push_back({FL_READ, 24'h000010, 16'd2}); push_rd(2);
        do_op(OP_READ, 24'h000010, 16'd2, ST_OK, 0, 2);

`ifdef FWU_FLASH_SEQ_WEL_CHECK_EN
        wel_bit = 1'b0;
        push_wren();
        do_op(OP_PROGRAM, 24'h000100, 16'd4, ST_WEL_FAIL, 0, 0);
        wel_bit = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
